// File: rtl/d2l_pkg.sv
// Shared definitions for the D2L master: FSM state encoding and frame timing.
package d2l_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DATA,
    ST_GUARD
  } d2l_state_e;

  localparam int GUARD_CYCLES = 2;

  // One bit leaves on each line per DATA cycle.
  function automatic int data_cycles(input int data_width);
    return data_width / 2;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/d2l_rr_arbiter.sv
// Round-robin selector: grants the first requester at or after ptr, wrapping.
module d2l_rr_arbiter
  import d2l_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan from the farthest offset down so the requester nearest ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = N'(1) << ((int'(ptr) + k) % N);
        idx   = IW'((int'(ptr) + k) % N);
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/d2l_master.sv
// D2L master: arbitrates requesters round-robin and shifts each payload out
// as bit pairs on two lines under an active-low per-slave chip select.
module d2l_master
  import d2l_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_SLAVES = 4,
  localparam int DEST_W = idx_width(NUM_SLAVES),
  localparam int REQ_W  = idx_width(NUM_REQ)
) (
  input  logic                          sclk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*DEST_W-1:0]     req_dest,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          OutLine0,
  output logic                          OutLine1,
  output logic [NUM_SLAVES-1:0]         CS,
  output logic                          busy,
  output logic                          done,
  output logic [REQ_W-1:0]              done_id,
  output logic                          dest_err
);
  localparam int DATA_CYCLES = data_cycles(DATA_WIDTH);
  localparam int CNT_MAX     = (DATA_CYCLES > GUARD_CYCLES) ? DATA_CYCLES : GUARD_CYCLES;
  localparam int CNT_W       = idx_width(CNT_MAX);

  d2l_state_e            state_reg;
  logic [REQ_W-1:0]      ptr_reg;
  logic [REQ_W-1:0]      id_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [NUM_SLAVES-1:0] cs_reg;
  logic                  line0_reg, line1_reg;
  logic                  done_reg, dest_err_reg;
  logic [REQ_W-1:0]      done_id_reg;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [DEST_W-1:0]     dest_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign dest_arr[gi] = req_dest[gi*DEST_W +: DEST_W];
  end

  logic [NUM_REQ-1:0] grant;
  logic [REQ_W-1:0]   win_idx;
  logic               win_any;

  d2l_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  logic                  idle;
  logic [DEST_W-1:0]     win_dest;
  logic                  dest_bad;
  logic [REQ_W-1:0]      win_ptr_next, id_ptr_next;

  assign idle         = (state_reg == ST_IDLE);
  assign win_dest     = dest_arr[win_idx];
  assign dest_bad     = (int'(win_dest) >= NUM_SLAVES);
  assign win_ptr_next = (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign id_ptr_next  = (id_reg == REQ_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
  assign req_ready    = (rstn && idle) ? grant : '0;

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      id_reg       <= '0;
      data_reg     <= '0;
      cnt_reg      <= '0;
      cs_reg       <= '1;
      line0_reg    <= 1'b0;
      line1_reg    <= 1'b0;
      done_reg     <= 1'b0;
      done_id_reg  <= '0;
      dest_err_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      dest_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (win_any) begin
            if (dest_bad) begin
              // Unroutable request is consumed but never framed.
              dest_err_reg <= 1'b1;
              ptr_reg      <= win_ptr_next;
            end else begin
              data_reg  <= data_arr[win_idx];
              id_reg    <= win_idx;
              cs_reg    <= ~(NUM_SLAVES'(1) << win_dest);
              state_reg <= ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          {line1_reg, line0_reg} <= data_reg[DATA_WIDTH-1 -: 2];
          data_reg  <= data_reg << 2;
          cnt_reg   <= '0;
          state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (cnt_reg == CNT_W'(DATA_CYCLES - 1)) begin
            cs_reg    <= '1;
            line0_reg <= 1'b0;
            line1_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_GUARD;
          end else begin
            {line1_reg, line0_reg} <= data_reg[DATA_WIDTH-1 -: 2];
            data_reg <= data_reg << 2;
            cnt_reg  <= cnt_reg + 1'b1;
          end
        end
        ST_GUARD: begin
          if (cnt_reg == CNT_W'(GUARD_CYCLES - 1)) begin
            done_reg    <= 1'b1;
            done_id_reg <= id_reg;
            ptr_reg     <= id_ptr_next;
            state_reg   <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign OutLine0 = line0_reg;
  assign OutLine1 = line1_reg;
  assign CS       = cs_reg;
  assign busy     = !idle;
  assign done     = done_reg;
  assign done_id  = done_id_reg;
  assign dest_err = dest_err_reg;
endmodule

// File: tb/tb_d2l_master.sv
// Self-checking bench for d2l_master: directed scenarios plus randomized
// round-robin traffic compared against a frame-level reference model.
module tb_d2l_master;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int NS  = 4;
  localparam int DSW = 2;
  localparam int NSB = 5;
  localparam int DBW = 3;

  logic sclk = 1'b0;
  logic rstn = 1'b0;

  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data  = '0;
  logic [NR*DSW-1:0] req_dest  = '0;
  logic [NR-1:0]     req_ready;
  logic              OutLine0, OutLine1, busy, done, dest_err;
  logic [NS-1:0]     CS;
  logic [1:0]        done_id;

  // Second instance with five slaves so an out-of-range dest (5) is encodable.
  logic [NR-1:0]     b_valid = '0;
  logic [NR*DW-1:0]  b_data  = '0;
  logic [NR*DBW-1:0] b_dest  = '0;
  logic [NR-1:0]     b_ready;
  logic              b_l0, b_l1, b_busy, b_done, b_dest_err;
  logic [NSB-1:0]    b_cs;
  logic [1:0]        b_done_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  d2l_master #(.DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_SLAVES(NS)) dut (
    .sclk(sclk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_dest(req_dest), .req_ready(req_ready), .OutLine0(OutLine0),
    .OutLine1(OutLine1), .CS(CS), .busy(busy), .done(done),
    .done_id(done_id), .dest_err(dest_err)
  );

  d2l_master #(.DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_SLAVES(NSB)) dut_b (
    .sclk(sclk), .rstn(rstn), .req_valid(b_valid), .req_data(b_data),
    .req_dest(b_dest), .req_ready(b_ready), .OutLine0(b_l0),
    .OutLine1(b_l1), .CS(b_cs), .busy(b_busy), .done(b_done),
    .done_id(b_done_id), .dest_err(b_dest_err)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Slave-side receiver: skips the select cycle, then shifts in (L1,L0) pairs.
  int            mon_len = 0;
  int            mon_slave = 0;
  logic [DW-1:0] mon_shift = '0;
  int            rx_frames = 0;
  logic [DW-1:0] rx_data = '0;
  int            rx_slave = -1;
  int            rx_len = 0;
  int            multi_cs = 0;
  int            done_pulses = 0;

  always @(negedge sclk) begin
    if (!rstn) begin
      mon_len = 0;
    end else if (CS != '1) begin
      if ($countones(~CS) != 1) multi_cs++;
      for (int s = 0; s < NS; s++) if (!CS[s]) mon_slave = s;
      if (mon_len > 0) mon_shift = {mon_shift[DW-3:0], OutLine1, OutLine0};
      mon_len++;
    end else if (mon_len != 0) begin
      rx_frames++;
      rx_data  = mon_shift;
      rx_slave = mon_slave;
      rx_len   = mon_len;
      mon_len  = 0;
    end
    if (rstn && done) done_pulses++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_winner(input logic [NR-1:0] mask, input int ptr);
    for (int k = 0; k < NR; k++) if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] d, input int dst);
    req_data[i*DW +: DW]   = d;
    req_dest[i*DSW +: DSW] = DSW'(dst);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    b_valid = '0;
    repeat (2) @(posedge sclk);
    #1 rstn = 1'b1;
  endtask

  // Returns once valid&ready is seen; the accept happens on the next rising edge.
  task automatic wait_accept(output int idx, output bit ok);
    ok = 1'b0;
    idx = -1;
    #1;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) idx = i;
      end else begin
        @(negedge sclk);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = '1;
    b_valid = '1;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (CS !== '1) begin errors++; $display("FAIL reset_cs: got %b want 1111", CS); end
    checks++; if ({OutLine1, OutLine0} !== 2'b00) begin errors++; $display("FAIL reset_lines: got %b want 00", {OutLine1, OutLine0}); end
    checks++; if ({busy, done, dest_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, dest_err}); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
    checks++; if (b_ready !== '0 || b_cs !== '1) begin errors++; $display("FAIL reset_b: ready %b cs %b want 0000 11111", b_ready, b_cs); end
    req_valid = '0;
    b_valid = '0;
    @(posedge sclk);
    #1 rstn = 1'b1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single_frame();
    int idx;
    bit ok;
    logic [DW-1:0] d;
    int dst;
    int base_rx;
    logic [NS-1:0] exp_cs;
    logic [1:0] exp_pair;
    d = 8'hB4;
    dst = 2;
    do_reset();
    set_req(0, d, dst);
    req_valid[0] = 1'b1;
    wait_accept(idx, ok);
    checks++; if (!ok || idx != 0) begin errors++; $display("FAIL single_accept: got %0d want 0", idx); end
    base_rx = rx_frames;
    for (int k = 0; k < 9; k++) begin
      @(posedge sclk);
      if (k == 0) #1 req_valid[0] = 1'b0;
      @(negedge sclk);
      exp_cs   = (k < 5) ? ~(NS'(1) << dst) : '1;
      exp_pair = (k >= 1 && k <= 4) ? 2'((d >> (DW - 2*k)) & 8'd3) : 2'b00;
      checks++; if (CS !== exp_cs) begin errors++; $display("FAIL single_cs[%0d]: got %b want %b", k, CS, exp_cs); end
      checks++; if ({OutLine1, OutLine0} !== exp_pair) begin errors++; $display("FAIL single_pair[%0d]: got %b want %b", k, {OutLine1, OutLine0}, exp_pair); end
      checks++; if (done !== (k == 7)) begin errors++; $display("FAIL single_done[%0d]: got %b want %b", k, done, (k == 7)); end
      checks++; if (busy !== (k < 7)) begin errors++; $display("FAIL single_busy[%0d]: got %b want %b", k, busy, (k < 7)); end
      if (k == 7) begin
        checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL single_done_id: got %0d want 0", done_id); end
      end
    end
    checks++; if (rx_frames != base_rx + 1 || rx_data !== d || rx_slave != dst || rx_len != 5) begin
      errors++; $display("FAIL single_rx: frames +%0d data %h slave %0d len %0d want +1 %h %0d 5", rx_frames - base_rx, rx_data, rx_slave, rx_len, d, dst);
    end
    $display("frame: req 0 data %h dest %0d received %h", d, dst, rx_data);
  endtask

  task automatic test_fairness();
    int idx, exp, ptr, prev_cyc;
    bit ok;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, DW'($urandom), int'($urandom_range(0, NS - 1)));
    req_valid = '1;
    ptr = 0;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_accept(idx, ok);
      exp = rr_winner(req_valid, ptr);
      checks++; if (!ok || idx != exp) begin errors++; $display("FAIL fair_grant[%0d]: got %0d want %0d", n, idx, exp); end
      if (n > 0) begin
        checks++; if (cyc - prev_cyc != 8) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d want 8", n, cyc - prev_cyc); end
      end
      $display("fairness: accept %0d granted req %0d at cycle %0d", n, idx, cyc);
      prev_cyc = cyc;
      ptr = (exp + 1) % NR;
      @(posedge sclk);
      #1 if (idx >= 0) set_req(idx, DW'($urandom), int'($urandom_range(0, NS - 1)));
    end
    req_valid = '0;
  endtask

  task automatic test_bad_dest();
    int errs, dones;
    logic [1:0] last_id;
    bit seen;
    do_reset();
    b_data[0*DW +: DW] = 8'h5A;
    b_dest[0*DBW +: DBW] = 3'd5;
    b_data[1*DW +: DW] = 8'hC3;
    b_dest[1*DBW +: DBW] = 3'd1;
    b_valid = 4'b0011;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge sclk);
      if (|(b_valid & b_ready)) seen = 1'b1;
    end
    checks++; if (!seen || b_ready !== 4'b0001) begin errors++; $display("FAIL bad_first_grant: got %b want 0001", b_ready); end
    @(posedge sclk);
    #1 b_valid[0] = 1'b0;
    @(negedge sclk);
    checks++; if (b_dest_err !== 1'b1) begin errors++; $display("FAIL bad_dest_err: got %b want 1", b_dest_err); end
    checks++; if (b_cs !== '1 || b_busy !== 1'b0) begin errors++; $display("FAIL bad_idle: cs %b busy %b want 11111 0", b_cs, b_busy); end
    checks++; if (b_ready !== 4'b0010) begin errors++; $display("FAIL bad_next_grant: got %b want 0010", b_ready); end
    @(posedge sclk);
    #1 b_valid[1] = 1'b0;
    @(negedge sclk);
    checks++; if (b_cs !== 5'b11101) begin errors++; $display("FAIL bad_next_cs: got %b want 11101", b_cs); end
    errs = 0;
    dones = 0;
    last_id = 2'd3;
    for (int n = 0; n < 12; n++) begin
      @(negedge sclk);
      if (b_dest_err) errs++;
      if (b_done) begin dones++; last_id = b_done_id; end
    end
    checks++; if (errs != 0) begin errors++; $display("FAIL bad_err_once: got %0d extra pulses want 0", errs); end
    checks++; if (dones != 1 || last_id !== 2'd1) begin errors++; $display("FAIL bad_done: got %0d pulses id %0d want 1 id 1", dones, last_id); end
    $display("bad dest: req 0 dest 5 rejected, req 1 served");
  endtask

  task automatic test_reset_mid();
    int idx, base_done, base_rx;
    bit ok;
    do_reset();
    set_req(0, DW'($urandom), int'($urandom_range(0, NS - 1)));
    req_valid[0] = 1'b1;
    wait_accept(idx, ok);
    base_done = done_pulses;
    @(posedge sclk);
    #1 req_valid[0] = 1'b0;
    repeat (3) @(posedge sclk);
    #1 rstn = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
    checks++; if (CS !== '1 || {OutLine1, OutLine0} !== 2'b00) begin errors++; $display("FAIL mid_abort_bus: cs %b lines %b want 1111 00", CS, {OutLine1, OutLine0}); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_abort_flags: busy %b done %b want 0 0", busy, done); end
    @(posedge sclk);
    #1 rstn = 1'b1;
    base_rx = rx_frames;
    set_req(0, 8'h3C, 1);
    req_valid[0] = 1'b1;
    wait_accept(idx, ok);
    checks++; if (!ok || idx != 0) begin errors++; $display("FAIL mid_reaccept: got %0d want 0", idx); end
    @(posedge sclk);
    #1 req_valid[0] = 1'b0;
    repeat (10) @(negedge sclk);
    checks++; if (done_pulses != base_done + 1) begin errors++; $display("FAIL mid_done_count: got +%0d want +1", done_pulses - base_done); end
    checks++; if (rx_frames != base_rx + 1 || rx_data !== 8'h3C || rx_slave != 1) begin
      errors++; $display("FAIL mid_rx: frames +%0d data %h slave %0d want +1 3c 1", rx_frames - base_rx, rx_data, rx_slave);
    end
    $display("reset mid-frame: follow-up frame received %h", rx_data);
  endtask

  task automatic test_simultaneous();
    int idx, prev_cyc;
    bit ok;
    logic [DW-1:0] d1;
    do_reset();
    set_req(2, DW'($urandom), int'($urandom_range(0, NS - 1)));
    req_valid[2] = 1'b1;
    wait_accept(idx, ok);
    checks++; if (!ok || idx != 2) begin errors++; $display("FAIL sim_first: got %0d want 2", idx); end
    prev_cyc = cyc;
    @(posedge sclk);
    #1 req_valid[2] = 1'b0;
    repeat (2) @(posedge sclk);
    d1 = DW'($urandom);
    #1 set_req(1, d1, 3);
    set_req(3, DW'($urandom), 0);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL sim_busy_ready: got %b want 0000", req_ready); end
    wait_accept(idx, ok);
    checks++; if (!ok || idx != 3) begin errors++; $display("FAIL sim_order_a: got %0d want 3", idx); end
    checks++; if (cyc - prev_cyc != 8) begin errors++; $display("FAIL sim_spacing: got %0d want 8", cyc - prev_cyc); end
    @(posedge sclk);
    #1 req_valid[3] = 1'b0;
    wait_accept(idx, ok);
    checks++; if (!ok || idx != 1) begin errors++; $display("FAIL sim_order_b: got %0d want 1", idx); end
    @(posedge sclk);
    #1 req_valid[1] = 1'b0;
    repeat (8) @(negedge sclk);
    checks++; if (rx_data !== d1 || rx_slave != 3) begin errors++; $display("FAIL sim_rx: data %h slave %0d want %h 3", rx_data, rx_slave, d1); end
    $display("simultaneous: req 3 then req 1 granted");
  endtask

  task automatic test_random();
    logic [NR-1:0] mask;
    logic [DW-1:0] exp_data [NR];
    int exp_dest [NR];
    int idx, exp, ptr;
    bit ok, got_done;
    do_reset();
    ptr = 0;
    for (int r = 0; r < 6; r++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        exp_data[i] = DW'($urandom);
        exp_dest[i] = int'($urandom_range(0, NS - 1));
        set_req(i, exp_data[i], exp_dest[i]);
      end
      req_valid = mask;
      while (mask != '0) begin
        wait_accept(idx, ok);
        exp = rr_winner(mask, ptr);
        checks++; if (!ok || idx != exp) begin errors++; $display("FAIL rand_grant[%0d]: got %0d want %0d", r, idx, exp); end
        if (!ok || idx < 0) begin
          mask = '0;
          req_valid = '0;
        end else begin
          @(posedge sclk);
          #1 req_valid[idx] = 1'b0;
          mask[idx] = 1'b0;
          got_done = 1'b0;
          for (int n = 0; n < 20 && !got_done; n++) begin
            @(negedge sclk);
            if (done) got_done = 1'b1;
          end
          checks++; if (!got_done || done_id !== 2'(idx)) begin errors++; $display("FAIL rand_done[%0d]: seen %b id %0d want 1 id %0d", r, got_done, done_id, idx); end
          checks++; if (rx_data !== exp_data[idx] || rx_slave != exp_dest[idx]) begin
            errors++; $display("FAIL rand_rx[%0d]: data %h slave %0d want %h %0d", r, rx_data, rx_slave, exp_data[idx], exp_dest[idx]);
          end
          $display("random: round %0d req %0d data %h dest %0d", r, idx, exp_data[idx], exp_dest[idx]);
          ptr = (exp + 1) % NR;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fairness();
    test_bad_dest();
    test_reset_mid();
    test_simultaneous();
    test_random();
    checks++; if (multi_cs != 0) begin errors++; $display("FAIL one_cs: got %0d cycles with several CS low want 0", multi_cs); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
